uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart to the team's 16x-oversampled UART transmitter. It shares the same baud tick (`s_tick`) and frame format: 1 start bit, DBIT data bits sent LSB first, and 1 stop bit. It synchronises the asynchronous `rx` line, samples each bit at mid-bit, and holds the received byte in a one-entry output buffer with a valid/ack handshake. It also reports framing and overrun errors.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, `s_tick` pulses per bit period. Must be even and ≥4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- rx  in  1  asynchronous serial input; idles high.
- s_tick  in  1  oversampling tick from the baud generator, one clk wide.
- rx_ack  in  1  consumer acknowledge; clears rx_valid.
- dout  out  DBIT  last accepted data byte.
- rx_valid  out  1  dout holds an unacknowledged byte.
- rx_done_tick  out  1  one-cycle pulse when a good frame completes.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun_err  out  1  sticky flag: a good frame completed while rx_valid was 1.
- parity_err  out  1  one-cycle pulse on parity mismatch. Constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Input synchroniser:
  - `rx` passes through a 2-FF synchroniser; rx_s is the second stage.
  - Both stages reset to 1. All decisions use rx_s.
  - Input-to-decision latency is 2 clk.
- Counters:
  - s_reg is $clog2(SB_TICK) bits wide; n_reg is $clog2(DBIT) bits wide.
  - b_reg is a DBIT-bit shift register.
  - Counters advance only on cycles where s_tick=1.
- States: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: when rx_s==0 (no tick needed), go to START with s_reg=0.
  - START: on each tick, s_reg increments. At the tick where s_reg==SB_TICK/2-1 (mid start bit):
    - if rx_s==0, go to DATA with s_reg=0 and n_reg=0;
    - else it is a false start (glitch): go to IDLE with no flags.
  - DATA: at the tick where s_reg==SB_TICK-1 (mid data bit):
    - b_reg <= {rx_s, b_reg[DBIT-1:1]}, and s_reg=0;
    - if n_reg==DBIT-1, go to STOP (or PARITY), else n_reg+1.
  - STOP: at the tick where s_reg==SB_TICK-1, sample rx_s:
    - 1: good frame;
    - 0: frame_err pulses high for that same cycle.
    - In both cases go to IDLE.
  - Exit from STOP happens at mid stop bit, so the receiver can resync to a start bit that immediately follows.
- Good-frame timing:
  - rx_done_tick is combinational: (state==STOP) & (s_reg==SB_TICK-1) & s_tick & rx_s & no parity_err.
  - On the following edge, dout<=b_reg.
- Output buffer:
  - On a good frame, rx_valid <= 1.
  - rx_ack==1 clears rx_valid on the next edge.
  - Good frame and rx_ack in the same cycle: rx_valid stays 1, dout takes the new byte, and no overrun is flagged.
  - Good frame while rx_valid==1 and rx_ack==0: dout is overwritten with the newer byte and overrun_err <= 1.
  - overrun_err is cleared only by rx_ack or reset.
- Bad frame (framing or parity error): dout, rx_valid and overrun_err are unchanged; the byte is dropped.
- Break condition (line held low): each frame reports frame_err, then the FSM restarts from IDLE. This is accepted behaviour.
- Reset values:
  - state=IDLE; s_reg, n_reg, b_reg = 0.
  - dout=0, rx_valid=0, overrun_err=0.
  - synchroniser stages = 1.
  - All pulse outputs are 0.
- Reset asserted mid-frame aborts the frame with no flags. Reception restarts on the next falling edge after reset is released.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds the PARITY state between DATA and STOP.
  - At the tick where s_reg==SB_TICK-1, the parity bit is compared with ^b_reg ^ PARITY_ODD.
  - On mismatch, parity_err pulses at the following stop-bit sample tick, the frame is discarded, and rx_done_tick is suppressed.
  - If both checks fail, frame_err and parity_err pulse together.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and parity_err is tied to 0.

Test Plan:
- Setup for all scenarios: SB_TICK=16, s_tick every 4 clk. Drive 0xA5 at the matching bit period with a stop bit of 1.
  - Expect one rx_done_tick, then dout=0xA5 and rx_valid=1.
  - Expect frame_err=0 and overrun_err=0.
- Pulse rx low for 5 ticks, then high → no rx_done_tick, no flags, FSM back in IDLE, rx_valid unchanged.
- Send 0x3C with a stop bit of 0 → frame_err pulses once, no rx_done_tick, dout and rx_valid unchanged. A following 0x81 is received correctly.
- Send 0x11 then 0x22 with no rx_ack → dout=0x22, overrun_err=1. Then pulse rx_ack → rx_valid=0 and overrun_err=0.
- Assert reset during data bit 3 of a frame → all outputs return to reset values, with no spurious pulse when the line returns high. A following 0x5A is received.
- With UART_RX_PARITY_EN and PARITY_ODD=0:
  - send 0x07 with parity bit 1 → good, dout=0x07;
  - send 0x07 with parity bit 0 → parity_err pulses and dout is unchanged.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver with a one-entry output buffer,
//               valid/ack handshake, framing and overrun error reporting.
//               Define UART_RX_PARITY_EN to add a parity bit check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rx_ack,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun_err,
    output logic            parity_err
);

    localparam int C_S_W = $clog2(SB_TICK);
    localparam int C_N_W = $clog2(DBIT);

    localparam logic [C_S_W-1:0] C_S_MID  = C_S_W'(SB_TICK / 2 - 1);
    localparam logic [C_S_W-1:0] C_S_LAST = C_S_W'(SB_TICK - 1);
    localparam logic [C_N_W-1:0] C_N_LAST = C_N_W'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    state_t            r_state;
    logic              r_rx_meta;
    logic              rx_s;
    logic [C_S_W-1:0]  s_reg;
    logic [C_N_W-1:0]  n_reg;
    logic [DBIT-1:0]   b_reg;
    logic              w_stop_sample;

    // Two-stage synchroniser; both stages idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            rx_s      <= r_rx_meta;
        end
    end

    assign w_stop_sample = (r_state == ST_STOP) && s_tick && (s_reg == C_S_LAST);
    assign frame_err     = w_stop_sample && !rx_s;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;

    assign parity_err   = w_stop_sample && r_par_bad;
    assign rx_done_tick = w_stop_sample && rx_s && !r_par_bad;
`else
    assign parity_err   = 1'b0;
    assign rx_done_tick = w_stop_sample && rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            s_reg   <= '0;
            n_reg   <= '0;
            b_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        r_state <= ST_START;
                        s_reg   <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_reg == C_S_MID) begin
                            // A start bit that is gone by mid-bit is treated as a glitch.
                            if (!rx_s) begin
                                r_state <= ST_DATA;
                                s_reg   <= '0;
                                n_reg   <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_reg == C_S_LAST) begin
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            s_reg <= '0;
                            if (n_reg == C_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                n_reg <= n_reg + 1'b1;
                            end
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_reg == C_S_LAST) begin
                            r_par_bad <= (rx_s != ((^b_reg) ^ PARITY_ODD));
                            s_reg     <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start bit is not missed.
                    if (s_tick) begin
                        if (s_reg == C_S_LAST) begin
                            r_state <= ST_IDLE;
                            s_reg   <= '0;
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-entry output buffer; a coincident ack lets the new byte in without overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout        <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else if (rx_done_tick) begin
            dout     <= b_reg;
            rx_valid <= 1'b1;
            if (rx_ack) begin
                overrun_err <= 1'b0;
            end else if (rx_valid) begin
                overrun_err <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
